mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller_if.sv | 58 +++++
 rtl/mc_controller.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_mc_controller.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_controller_if.sv
// -----------------------------------------------------------------------------
// mc_controller_if
// Bundles the instruction/memory handshake inputs and the datapath control
// strobes of the multi-cycle controller.
//
// Signals:
//   opcode[6:0]  instruction opcode from the datapath instruction register
//   stall        hold request, blocks the start of a new fetch
//   mem_ready    memory handshake, access completes in the cycle it is high
//   PCWrite, IRWrite, RegWrite, MemRead, MemWrite, ALUSrc, MemtoReg
//                datapath control strobes
//   ALUOp[1:0]   00 add, 10 R-type, 11 I-type ALU
//   inst_done    one-cycle retirement pulse
//   trap         sticky fault flag
//   retired[31:0] retired-instruction count (only with MC_RETIRE_CNT_EN)
//
// Modports:
//   master  the controller (drives the strobes)
//   slave   the datapath / memory side (drives opcode, stall, mem_ready)
//
// Configuration macro: MC_RETIRE_CNT_EN adds the retired counter signal.
// -----------------------------------------------------------------------------
interface mc_controller_if;
    logic [6:0]  opcode;
    logic        stall;
    logic        mem_ready;
    logic        PCWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        ALUSrc;
    logic        MemtoReg;
    logic [1:0]  ALUOp;
    logic        inst_done;
    logic        trap;
`ifdef MC_RETIRE_CNT_EN
    logic [31:0] retired;
`endif

    modport master (
        input  opcode, stall, mem_ready,
`ifdef MC_RETIRE_CNT_EN
        output retired,
`endif
        output PCWrite, IRWrite, RegWrite, MemRead, MemWrite,
        output ALUSrc, MemtoReg, ALUOp, inst_done, trap
    );

    modport slave (
        output opcode, stall, mem_ready,
`ifdef MC_RETIRE_CNT_EN
        input  retired,
`endif
        input  PCWrite, IRWrite, RegWrite, MemRead, MemWrite,
        input  ALUSrc, MemtoReg, ALUOp, inst_done, trap
    );
endinterface

// File: rtl/mc_controller.sv
// -----------------------------------------------------------------------------
// mc_controller
// Multi-cycle RV32-subset control FSM: FETCH -> DECODE -> EXECUTE -> (MEM) ->
// (WB) -> FETCH, with a memory wait watchdog and a sticky TRAP state.
// Supported opcodes: R-type 0110011, I-type ALU 0010011, load 0000011,
// store 0100011. Any other opcode traps after DECODE.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset; forces FETCH and zeroes outputs
//   bus    mc_controller_if.master (opcode/stall/mem_ready in, strobes out)
//
// Parameter:
//   TIMEOUT  consecutive mem_ready=0 cycles tolerated in a memory state
//            before trapping (1..255)
//
// Configuration macro: MC_RETIRE_CNT_EN enables the 32-bit retired counter.
// -----------------------------------------------------------------------------
module mc_controller #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    mc_controller_if.master   bus
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_TRAP    = 3'd5
    } state_e;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    // Opcodes the controller knows how to sequence
    function automatic logic is_legal(input logic [6:0] op);
        logic legal;
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE: legal = 1'b1;
            default:                       legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Opcodes that need a MEM phase
    function automatic logic is_mem_op(input logic [6:0] op);
        logic mem;
        case (op)
            OP_LOAD, OP_STORE: mem = 1'b1;
            default:           mem = 1'b0;
        endcase
        return mem;
    endfunction

    state_e      state_q, state_d;
    logic [6:0]  opcode_q, opcode_d;
    logic [7:0]  wait_q, wait_d;

    logic        pc_write_s;
    logic        ir_write_s;
    logic        reg_write_s;
    logic        mem_read_s;
    logic        mem_write_s;
    logic        alu_src_s;
    logic        mem_to_reg_s;
    logic [1:0]  alu_op_s;
    logic        inst_done_s;
    logic        trap_s;

    // State register with asynchronous return to FETCH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched opcode and memory wait counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opcode_q <= 7'd0;
            wait_q   <= 8'd0;
        end else begin
            opcode_q <= opcode_d;
            wait_q   <= wait_d;
        end
    end

    // Next-state, opcode latch and wait-counter logic.
    // The watchdog fires on the cycle the counter would reach TIMEOUT, so
    // TIMEOUT unanswered wait cycles land in TRAP on the following cycle.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        wait_d   = 8'd0;
        case (state_q)
            S_FETCH: begin
                if (bus.stall) begin
                    state_d = S_FETCH;
                end else if (bus.mem_ready) begin
                    state_d = S_DECODE;
                end else if (wait_q == (TIMEOUT_C - 8'd1)) begin
                    state_d = S_TRAP;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                opcode_d = bus.opcode;
                if (is_legal(bus.opcode)) begin
                    state_d = S_EXECUTE;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_EXECUTE: begin
                if (is_mem_op(opcode_q)) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (bus.mem_ready) begin
                    if (opcode_q == OP_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else if (wait_q == (TIMEOUT_C - 8'd1)) begin
                    state_d = S_TRAP;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                // Unreachable encoding: treat as a fault
                state_d = S_TRAP;
            end
        endcase
    end

    // Control strobes decoded from state, latched opcode and handshake
    always_comb begin
        pc_write_s   = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        alu_src_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        alu_op_s     = 2'b00;
        inst_done_s  = 1'b0;
        trap_s       = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (!bus.stall) begin
                    mem_read_s = 1'b1;
                    ir_write_s = 1'b1;
                    pc_write_s = bus.mem_ready;
                end else begin
                    mem_read_s = 1'b0;
                end
            end
            S_DECODE: begin
                trap_s = 1'b0;
            end
            S_EXECUTE: begin
                case (opcode_q)
                    OP_R: begin
                        alu_op_s  = 2'b10;
                        alu_src_s = 1'b0;
                    end
                    OP_I: begin
                        alu_op_s  = 2'b11;
                        alu_src_s = 1'b1;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_op_s  = 2'b00;
                        alu_src_s = 1'b1;
                    end
                    default: begin
                        alu_op_s  = 2'b00;
                        alu_src_s = 1'b0;
                    end
                endcase
            end
            S_MEM: begin
                alu_op_s  = 2'b00;
                alu_src_s = 1'b1;
                if (opcode_q == OP_STORE) begin
                    mem_write_s = 1'b1;
                    // A store retires in the cycle its write completes
                    inst_done_s = bus.mem_ready;
                end else if (opcode_q == OP_LOAD) begin
                    mem_read_s = 1'b1;
                end else begin
                    mem_read_s = 1'b0;
                end
            end
            S_WB: begin
                reg_write_s  = 1'b1;
                inst_done_s  = 1'b1;
                mem_to_reg_s = (opcode_q == OP_LOAD);
            end
            S_TRAP: begin
                trap_s = 1'b1;
            end
            default: begin
                trap_s = 1'b0;
            end
        endcase
    end

    // Outputs held low whenever reset is asserted, independent of the clock,
    // so an access interrupted by reset never shows a write or retire pulse.
    always_comb begin
        if (!reset) begin
            bus.PCWrite   = 1'b0;
            bus.IRWrite   = 1'b0;
            bus.RegWrite  = 1'b0;
            bus.MemRead   = 1'b0;
            bus.MemWrite  = 1'b0;
            bus.ALUSrc    = 1'b0;
            bus.MemtoReg  = 1'b0;
            bus.ALUOp     = 2'b00;
            bus.inst_done = 1'b0;
            bus.trap      = 1'b0;
        end else begin
            bus.PCWrite   = pc_write_s;
            bus.IRWrite   = ir_write_s;
            bus.RegWrite  = reg_write_s;
            bus.MemRead   = mem_read_s;
            bus.MemWrite  = mem_write_s;
            bus.ALUSrc    = alu_src_s;
            bus.MemtoReg  = mem_to_reg_s;
            bus.ALUOp     = alu_op_s;
            bus.inst_done = inst_done_s;
            bus.trap      = trap_s;
        end
    end

`ifdef MC_RETIRE_CNT_EN
    logic [31:0] retired_q, retired_d;

    // Retired count next value; wraps naturally at 32 bits
    always_comb begin
        if (inst_done_s) begin
            retired_d = retired_q + 32'd1;
        end else begin
            retired_d = retired_q;
        end
    end

    // Retired-instruction counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_q <= 32'd0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign bus.retired = retired_q;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// -----------------------------------------------------------------------------
// tb_mc_controller
// Directed, table-driven bench for mc_controller (TIMEOUT=15). One table row
// per clock cycle: inputs are driven on the falling edge and the packed
// control outputs are compared 1 time unit later. Hand-written sequences
// cover asynchronous reset between edges, the wait watchdog in FETCH and MEM,
// trap stickiness and (with MC_RETIRE_CNT_EN) the retired counter.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mc_controller;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    // {PCWrite, IRWrite, RegWrite, MemRead, MemWrite, ALUSrc, MemtoReg,
    //  ALUOp[1:0], inst_done, trap}
    localparam logic [10:0] E_NONE     = 11'b000_0000_00_0_0;
    localparam logic [10:0] E_FETCH    = 11'b110_1000_00_0_0;
    localparam logic [10:0] E_FETCHW   = 11'b010_1000_00_0_0;
    localparam logic [10:0] E_EXE_R    = 11'b000_0000_10_0_0;
    localparam logic [10:0] E_EXE_I    = 11'b000_0010_11_0_0;
    localparam logic [10:0] E_EXE_LS   = 11'b000_0010_00_0_0;
    localparam logic [10:0] E_MEM_LD   = 11'b000_1010_00_0_0;
    localparam logic [10:0] E_MEM_ST_W = 11'b000_0110_00_0_0;
    localparam logic [10:0] E_MEM_ST_D = 11'b000_0110_00_1_0;
    localparam logic [10:0] E_WB_R     = 11'b001_0000_00_1_0;
    localparam logic [10:0] E_WB_LD    = 11'b001_0001_00_1_0;
    localparam logic [10:0] E_TRAP     = 11'b000_0000_00_0_1;

    typedef struct {
        logic        rst_n;
        logic [6:0]  op;
        logic        stall;
        logic        rdy;
        logic [10:0] exp;
        string       tag;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] got;
    int          n_vec = 0;
    int          n_bad = 0;
    vec_t        tbl[$];

    mc_controller_if bus();

    mc_controller #(.TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    assign got = {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemRead,
                  bus.MemWrite, bus.ALUSrc, bus.MemtoReg, bus.ALUOp,
                  bus.inst_done, bus.trap};

    task automatic add(input logic r, input logic [6:0] op, input logic st,
                       input logic rdy, input logic [10:0] e, input string tag);
        vec_t v;
        v.rst_n = r;
        v.op    = op;
        v.stall = st;
        v.rdy   = rdy;
        v.exp   = e;
        v.tag   = tag;
        tbl.push_back(v);
    endtask

    task automatic check(input string tag, input logic [10:0] e);
        n_vec++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL %s: outputs %b, expected %b", tag, got, e);
        end
    endtask

    task automatic step(input logic r, input logic [6:0] op, input logic st,
                        input logic rdy, input logic [10:0] e, input string tag);
        @(negedge clk);
        reset         = r;
        bus.opcode    = op;
        bus.stall     = st;
        bus.mem_ready = rdy;
        #1;
        check(tag, e);
    endtask

`ifdef MC_RETIRE_CNT_EN
    task automatic check32(input string tag, input logic [31:0] e);
        n_vec++;
        if (bus.retired !== e) begin
            n_bad++;
            $display("FAIL %s: retired %h, expected %h", tag, bus.retired, e);
        end
    endtask

    task automatic run_store(input string tag);
        step(1'b1, OP_ST, 1'b0, 1'b1, E_FETCH,    tag);
        step(1'b1, OP_ST, 1'b0, 1'b1, E_NONE,     tag);
        step(1'b1, OP_ST, 1'b0, 1'b1, E_EXE_LS,   tag);
        step(1'b1, OP_ST, 1'b0, 1'b1, E_MEM_ST_D, tag);
    endtask
`endif

    initial begin
        reset         = 1'b1;
        bus.opcode    = 7'd0;
        bus.stall     = 1'b0;
        bus.mem_ready = 1'b0;
        #2 reset = 1'b0;

        // Reset, then each instruction class with zero-wait memory
        add(1'b0, OP_R,  1'b0, 1'b1, E_NONE,     "reset");
        add(1'b1, OP_R,  1'b0, 1'b1, E_FETCH,    "r_fetch");
        add(1'b1, OP_R,  1'b0, 1'b1, E_NONE,     "r_decode");
        add(1'b1, OP_R,  1'b0, 1'b1, E_EXE_R,    "r_exec");
        add(1'b1, OP_R,  1'b0, 1'b1, E_WB_R,     "r_wb");
        add(1'b1, OP_I,  1'b0, 1'b1, E_FETCH,    "i_fetch");
        add(1'b1, OP_I,  1'b0, 1'b1, E_NONE,     "i_decode");
        add(1'b1, OP_I,  1'b0, 1'b1, E_EXE_I,    "i_exec");
        add(1'b1, OP_I,  1'b0, 1'b1, E_WB_R,     "i_wb");
        add(1'b1, OP_ST, 1'b0, 1'b1, E_FETCH,    "st_fetch");
        add(1'b1, OP_ST, 1'b0, 1'b1, E_NONE,     "st_decode");
        add(1'b1, OP_ST, 1'b0, 1'b1, E_EXE_LS,   "st_exec");
        add(1'b1, OP_ST, 1'b0, 1'b0, E_MEM_ST_W, "st_mem_wait");
        add(1'b1, OP_ST, 1'b0, 1'b1, E_MEM_ST_D, "st_mem_done");
        // Load with three MEM wait cycles: 8 cycles in total
        add(1'b1, OP_LD, 1'b0, 1'b1, E_FETCH,    "ld_fetch");
        add(1'b1, OP_LD, 1'b0, 1'b1, E_NONE,     "ld_decode");
        add(1'b1, OP_LD, 1'b0, 1'b1, E_EXE_LS,   "ld_exec");
        add(1'b1, OP_LD, 1'b0, 1'b0, E_MEM_LD,   "ld_mem_w1");
        add(1'b1, OP_LD, 1'b0, 1'b0, E_MEM_LD,   "ld_mem_w2");
        add(1'b1, OP_LD, 1'b0, 1'b0, E_MEM_LD,   "ld_mem_w3");
        add(1'b1, OP_LD, 1'b0, 1'b1, E_MEM_LD,   "ld_mem_done");
        add(1'b1, OP_LD, 1'b0, 1'b1, E_WB_LD,    "ld_wb");
        // Stall with mem_ready high blocks the fetch
        for (int i = 0; i < 5; i++) begin
            add(1'b1, OP_R, 1'b1, 1'b1, E_NONE, "stall_hold");
        end
        add(1'b1, OP_R,  1'b0, 1'b1, E_FETCH,    "unstall_fetch");
        add(1'b1, OP_R,  1'b0, 1'b1, E_NONE,     "latch_decode");
        add(1'b1, OP_LD, 1'b0, 1'b1, E_EXE_R,    "latch_exec");
        add(1'b1, OP_LD, 1'b0, 1'b1, E_WB_R,     "latch_wb");
        // Short fetch wait, then an illegal opcode
        add(1'b1, OP_R,   1'b0, 1'b0, E_FETCHW,  "fetch_wait1");
        add(1'b1, OP_R,   1'b0, 1'b0, E_FETCHW,  "fetch_wait2");
        add(1'b1, OP_BAD, 1'b0, 1'b1, E_FETCH,   "bad_fetch");
        add(1'b1, OP_BAD, 1'b0, 1'b1, E_NONE,    "bad_decode");
        add(1'b1, OP_R,   1'b0, 1'b1, E_TRAP,    "trap_a");
        add(1'b1, OP_R,   1'b1, 1'b0, E_TRAP,    "trap_b");
        add(1'b0, OP_R,   1'b0, 1'b1, E_NONE,    "trap_clear");
        // Reset in WB and in MEM aborts with no strobes
        add(1'b1, OP_R,  1'b0, 1'b1, E_FETCH,    "ab_fetch");
        add(1'b1, OP_R,  1'b0, 1'b1, E_NONE,     "ab_decode");
        add(1'b1, OP_R,  1'b0, 1'b1, E_EXE_R,    "ab_exec");
        add(1'b0, OP_R,  1'b0, 1'b1, E_NONE,     "abort_wb");
        add(1'b1, OP_ST, 1'b0, 1'b1, E_FETCH,    "after_abort_wb");
        add(1'b1, OP_ST, 1'b0, 1'b1, E_NONE,     "ab_st_decode");
        add(1'b1, OP_ST, 1'b0, 1'b1, E_EXE_LS,   "ab_st_exec");
        add(1'b0, OP_ST, 1'b0, 1'b1, E_NONE,     "abort_mem");
        add(1'b1, OP_ST, 1'b0, 1'b1, E_FETCH,    "after_abort_mem");
        add(1'b1, OP_R,  1'b0, 1'b1, E_NONE,     "tail_decode");
        add(1'b1, OP_R,  1'b0, 1'b1, E_EXE_R,    "tail_exec");

        foreach (tbl[i]) begin
            step(tbl[i].rst_n, tbl[i].op, tbl[i].stall, tbl[i].rdy,
                 tbl[i].exp, tbl[i].tag);
        end

        // Asynchronous reset between clock edges while in WB
        @(negedge clk);
        reset = 1'b1; bus.opcode = OP_R; bus.stall = 1'b0; bus.mem_ready = 1'b1;
        #1 check("async_wb", E_WB_R);
        #2 reset = 1'b0;
        #1 check("async_rst_low", E_NONE);
        #1 reset = 1'b1;
        #1 check("async_rst_fetch", E_FETCH);
        step(1'b1, OP_R, 1'b0, 1'b1, E_NONE,  "async_decode");
        step(1'b1, OP_R, 1'b0, 1'b1, E_EXE_R, "async_exec");
        step(1'b1, OP_R, 1'b0, 1'b1, E_WB_R,  "async_wb2");

        // Fetch watchdog: 15 unanswered wait cycles trap on the 16th
        for (int i = 0; i < 15; i++) begin
            step(1'b1, OP_R, 1'b0, 1'b0, E_FETCHW, "to_wait");
        end
        step(1'b1, OP_R, 1'b0, 1'b0, E_TRAP, "to_trap");
        for (int i = 0; i < 100; i++) begin
            step(1'b1, i[0] ? OP_R : OP_ST, i[1], i[0], E_TRAP, "trap_sticky");
        end
        step(1'b0, OP_R, 1'b0, 1'b0, E_NONE, "trap_reset");

        // 14 wait cycles then ready: normal decode
        for (int i = 0; i < 14; i++) begin
            step(1'b1, OP_R, 1'b0, 1'b0, E_FETCHW, "wait14");
        end
        step(1'b1, OP_R, 1'b0, 1'b1, E_FETCH, "wait14_ready");
        step(1'b1, OP_R, 1'b0, 1'b1, E_NONE,  "wait14_decode");
        step(1'b1, OP_R, 1'b0, 1'b1, E_EXE_R, "wait14_exec");
        step(1'b1, OP_R, 1'b0, 1'b1, E_WB_R,  "wait14_wb");

        // A stall cycle clears the wait count: 10 + 14 waits stay legal
        for (int i = 0; i < 10; i++) begin
            step(1'b1, OP_ST, 1'b0, 1'b0, E_FETCHW, "pre_stall_wait");
        end
        step(1'b1, OP_ST, 1'b1, 1'b0, E_NONE, "stall_clear");
        for (int i = 0; i < 14; i++) begin
            step(1'b1, OP_ST, 1'b0, 1'b0, E_FETCHW, "post_stall_wait");
        end
        step(1'b1, OP_ST, 1'b0, 1'b1, E_FETCH,  "post_stall_fetch");
        step(1'b1, OP_ST, 1'b0, 1'b1, E_NONE,   "mto_decode");
        step(1'b1, OP_ST, 1'b0, 1'b1, E_EXE_LS, "mto_exec");
        // MEM watchdog
        for (int i = 0; i < 15; i++) begin
            step(1'b1, OP_ST, 1'b0, 1'b0, E_MEM_ST_W, "mem_wait");
        end
        step(1'b1, OP_ST, 1'b0, 1'b0, E_TRAP, "mem_trap");
        step(1'b0, OP_R,  1'b0, 1'b0, E_NONE, "mem_trap_reset");

`ifdef MC_RETIRE_CNT_EN
        check32("retired_reset", 32'd0);
        for (int i = 0; i < 10; i++) begin
            run_store("ret_store");
        end
        step(1'b1, OP_ST, 1'b1, 1'b0, E_NONE, "ret_idle");
        check32("retired_10", 32'd10);
        force dut.retired_q = 32'hFFFF_FFFF;
        #1 release dut.retired_q;
        check32("retired_preset", 32'hFFFF_FFFF);
        run_store("wrap_store");
        step(1'b1, OP_ST, 1'b1, 1'b0, E_NONE, "wrap_idle");
        check32("retired_wrap", 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
